// File: rtl/multicyc_issue_pkg.sv
// Shared types for the multicycle HI/LO issue path: operation codes,
// request/response records and the issue FSM state encoding.
package multicyc_issue_pkg;

    typedef logic [31:0] uint32_t;
    typedef logic [63:0] uint64_t;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MTHI,
        OP_MTLO,
        OP_MFHI,
        OP_MFLO
    } oper_t;

    typedef enum logic [1:0] {
        MI_IDLE,
        MI_BUSY,
        MI_DRAIN
    } mi_state_t;

    typedef struct packed {
        logic    is_multicyc;
        oper_t   op;
        uint32_t reg0;
        uint32_t reg1;
        uint64_t hilo;
    } multicyc_req_t;

    typedef struct packed {
        logic    ready;
        logic    valid;
        uint64_t hilo;
    } multicyc_resp_t;

    // Operations that must be handed to the multicycle responder
    function automatic logic is_multicyc_op(oper_t op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    endfunction

    function automatic logic is_mf_op(oper_t op);
        return op inside {OP_MFHI, OP_MFLO};
    endfunction

endpackage

// File: rtl/multicyc_issue_if.sv
// Request/response link between the EX-stage issuer (master) and the
// multicycle HI/LO responder (slave).
interface multicyc_issue_if;
    import multicyc_issue_pkg::*;

    multicyc_req_t  req;
    multicyc_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);

endinterface

// File: rtl/multicyc_issue.sv
// EX-stage initiator for the multicycle HI/LO unit: owns HILO, issues requests,
// stalls EX, drains flushed results. Optional macro HILO_BYPASS_EN.
module multicyc_issue
    import multicyc_issue_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  oper_t                   ex_op,
    input  uint32_t                 ex_reg0,
    input  uint32_t                 ex_reg1,
    input  logic                    flush,
    multicyc_issue_if.master        mc,
    output logic                    stall,
    output uint32_t                 mf_data,
    output uint64_t                 hilo
);

    mi_state_t     state_q, state_d;
    uint64_t       hilo_q, hilo_d;
    logic          is_mc, is_mf, issue;
    logic          stall_raw;
    uint64_t       mf_src;
    multicyc_req_t req;

    assign is_mc = ex_valid && is_multicyc_op(ex_op);
    assign is_mf = ex_valid && is_mf_op(ex_op);
    assign issue = (state_q == MI_IDLE) && is_mc && !flush && mc.resp.ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MI_IDLE;
            hilo_q  <= '0;
        end else begin
            state_q <= state_d;
            hilo_q  <= hilo_d;
        end
    end

    // A result arriving together with a flush still commits: its instruction completed.
    always_comb begin
        state_d = state_q;
        hilo_d  = hilo_q;
        case (state_q)
            MI_IDLE: begin
                if (issue) state_d = MI_BUSY;
            end
            MI_BUSY: begin
                if (mc.resp.valid) begin
                    hilo_d  = mc.resp.hilo;
                    state_d = MI_IDLE;
                end else if (flush) begin
                    state_d = MI_DRAIN;
                end
            end
            MI_DRAIN: begin
                if (mc.resp.valid) state_d = MI_IDLE;
            end
            default: state_d = MI_IDLE;
        endcase
    end

    always_comb begin
        req       = '0;
        stall_raw = 1'b0;
        mf_src    = hilo_q;
        case (state_q)
            MI_IDLE: begin
                stall_raw = is_mc;
                if (issue) begin
                    req.is_multicyc = 1'b1;
                    req.op          = ex_op;
                    req.reg0        = ex_reg0;
                    req.reg1        = ex_reg1;
                    req.hilo        = hilo_q;
                end
            end
            MI_BUSY: begin
                if (mc.resp.valid) begin
`ifdef HILO_BYPASS_EN
                    stall_raw = 1'b0;
                    mf_src    = mc.resp.hilo;
`else
                    stall_raw = is_mf;
`endif
                end else begin
                    stall_raw = 1'b1;
                end
            end
            MI_DRAIN: begin
                stall_raw = is_mc || is_mf;
            end
            default: stall_raw = 1'b0;
        endcase
    end

    assign stall   = stall_raw && !flush && !rst;
    assign mf_data = !is_mf ? '0 : ((ex_op == OP_MFHI) ? mf_src[63:32] : mf_src[31:0]);
    assign mc.req  = req;
    assign hilo    = hilo_q;

endmodule

// File: tb/tb_multicyc_issue.sv
// Scoreboard bench for multicyc_issue with a behavioural responder model
// (MTHI/MTLO latency 1, MULT/MULTU 2, DIV/DIVU 37).
module tb_multicyc_issue;
    import multicyc_issue_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    ex_valid;
    oper_t   ex_op;
    uint32_t ex_reg0, ex_reg1;
    logic    flush;
    logic    stall;
    uint32_t mf_data;
    uint64_t hilo;

    int      n_checks = 0;
    int      n_errors = 0;
    uint64_t sb_q[$];

    multicyc_issue_if mc_bus();

    multicyc_issue dut (
        .clk     (clk),
        .rst     (rst),
        .ex_valid(ex_valid),
        .ex_op   (ex_op),
        .ex_reg0 (ex_reg0),
        .ex_reg1 (ex_reg1),
        .flush   (flush),
        .mc      (mc_bus),
        .stall   (stall),
        .mf_data (mf_data),
        .hilo    (hilo)
    );

    always #5 clk = ~clk;

    // Responder model: latches a request only while idle, cannot be aborted
    logic    rsp_busy;
    int      rsp_cnt;
    uint64_t rsp_res;
    logic    rsp_valid;

    function automatic int latency(oper_t op);
        case (op)
            OP_MULT, OP_MULTU: return 2;
            OP_DIV, OP_DIVU:   return 37;
            default:           return 1;
        endcase
    endfunction

    function automatic uint64_t compute(multicyc_req_t r);
        logic signed [63:0] sa, sb;
        logic signed [31:0] a, b, q, m;
        sa = {{32{r.reg0[31]}}, r.reg0};
        sb = {{32{r.reg1[31]}}, r.reg1};
        a  = r.reg0;
        b  = r.reg1;
        case (r.op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return {32'h0, r.reg0} * {32'h0, r.reg1};
            OP_DIV: begin
                if (b == 0) return r.hilo;
                q = a / b;
                m = a % b;
                return {m, q};
            end
            OP_DIVU: begin
                if (r.reg1 == 0) return r.hilo;
                return {r.reg0 % r.reg1, r.reg0 / r.reg1};
            end
            OP_MTHI:  return {r.reg0, r.hilo[31:0]};
            OP_MTLO:  return {r.hilo[63:32], r.reg0};
            default:  return r.hilo;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            rsp_busy <= 1'b0;
            rsp_cnt  <= 0;
            rsp_res  <= '0;
        end else if (rsp_busy) begin
            if (rsp_cnt == 0) rsp_busy <= 1'b0;
            else              rsp_cnt  <= rsp_cnt - 1;
        end else if (mc_bus.req.is_multicyc) begin
            rsp_busy <= 1'b1;
            rsp_cnt  <= latency(mc_bus.req.op) - 1;
            rsp_res  <= compute(mc_bus.req);
        end
    end

    assign rsp_valid   = rsp_busy && (rsp_cnt == 0);
    assign mc_bus.resp = {!rsp_busy, rsp_valid, rsp_valid ? rsp_res : 64'h0};

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(logic v, oper_t op, uint32_t a, uint32_t b, logic fl);
        ex_valid = v;
        ex_op    = op;
        ex_reg0  = a;
        ex_reg1  = b;
        flush    = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, follow it to its valid cycle and leave at the start of the next cycle
    task automatic run_op(string name, oper_t op, uint32_t a, uint32_t b, int lat,
                          uint64_t exp_req_hilo, uint64_t exp_res);
        applyStimulus(1'b1, op, a, b, 1'b0);
        sb_q.push_back(exp_res);
        @(negedge clk);
        checkOutput({name, "_issue"}, 64'(mc_bus.req.is_multicyc), 64'd1);
        checkOutput({name, "_req_op"}, 64'(mc_bus.req.op), 64'(op));
        checkOutput({name, "_req_regs"}, {mc_bus.req.reg0, mc_bus.req.reg1}, {a, b});
        checkOutput({name, "_req_hilo"}, mc_bus.req.hilo, exp_req_hilo);
        checkOutput({name, "_stall_t0"}, 64'(stall), 64'd1);
        for (int k = 1; k <= lat; k++) begin
            next_cycle();
            @(negedge clk);
            checkOutput({name, "_busy_flags"},
                        64'({mc_bus.req.is_multicyc, stall, mc_bus.resp.valid}),
                        (k < lat) ? 64'b010 : 64'b001);
        end
        next_cycle();
    endtask

    // Monitor: the cycle after every response valid, HILO must hold the queued expectation
    initial begin
        logic seen;
        uint64_t exp_h;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (seen) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL commit_unexpected: got hilo 0x%0h, expected no commit", hilo);
                end else begin
                    exp_h = sb_q.pop_front();
                    checkOutput("commit_hilo", hilo, exp_h);
                end
            end
            seen = mc_bus.resp.valid && !rst;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, OP_MULT, 32'd5, 32'd6, 1'b0);
        next_cycle();
        @(negedge clk);
        checkOutput("reset_no_issue", 64'({mc_bus.req.is_multicyc, stall}), 64'd0);
        next_cycle();
        rst = 1'b0;
        applyStimulus(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("reset_hilo", hilo, 64'd0);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        checkOutput("reset_mf_data", 64'(mf_data), 64'd0);
        checkOutput("reset_req_zero", 64'(mc_bus.req == '0), 64'd1);
        next_cycle();

        applyStimulus(1'b1, OP_ADD, 32'd1, 32'd2, 1'b0);
        @(negedge clk);
        checkOutput("alu_no_stall", 64'({mc_bus.req.is_multicyc, stall}), 64'd0);
        next_cycle();
        applyStimulus(1'b1, OP_MULT, 32'd2, 32'd3, 1'b1);
        @(negedge clk);
        checkOutput("flush_blocks_issue", 64'({mc_bus.req.is_multicyc, stall}), 64'd0);
        next_cycle();

        run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 2, 64'd0, 64'hFFFFFFFF_FFFFFFFA);
        applyStimulus(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mfhi_after_mult", 64'(mf_data), 64'hFFFFFFFF);
        checkOutput("mfhi_no_stall", 64'(stall), 64'd0);
        next_cycle();

        run_op("div", OP_DIV, 32'd7, 32'hFFFFFFFE, 37, 64'hFFFFFFFF_FFFFFFFA, 64'h00000001_FFFFFFFD);
        applyStimulus(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mflo_after_div", 64'(mf_data), 64'hFFFFFFFD);
        next_cycle();

        rst = 1'b1;
        applyStimulus(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
        next_cycle();
        rst = 1'b0;
        applyStimulus(1'b1, OP_MTHI, 32'h12345678, 32'd0, 1'b0);
        sb_q.push_back(64'h12345678_00000000);
        @(negedge clk);
        checkOutput("mthi_issue", 64'(mc_bus.req.is_multicyc), 64'd1);
        checkOutput("mthi_req_hilo", mc_bus.req.hilo, 64'd0);
        next_cycle();
        applyStimulus(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mthi_valid", 64'(mc_bus.resp.valid), 64'd1);
`ifdef HILO_BYPASS_EN
        checkOutput("mfhi_bypass_stall", 64'(stall), 64'd0);
        checkOutput("mfhi_bypass_data", 64'(mf_data), 64'h12345678);
`else
        checkOutput("mfhi_valid_cycle_stall", 64'(stall), 64'd1);
        checkOutput("mfhi_valid_cycle_data", 64'(mf_data), 64'd0);
`endif
        next_cycle();
        @(negedge clk);
        checkOutput("mfhi_after_mthi", 64'(mf_data), 64'h12345678);
        checkOutput("mfhi_after_mthi_stall", 64'(stall), 64'd0);
        next_cycle();

        run_op("mtlo", OP_MTLO, 32'hCAFEBABE, 32'd0, 1, 64'h12345678_00000000, 64'h12345678_CAFEBABE);
        applyStimulus(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mflo_after_mtlo", 64'(mf_data), 64'hCAFEBABE);
        next_cycle();

        applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
        sb_q.push_back(64'h12345678_CAFEBABE);
        @(negedge clk);
        checkOutput("divu_issue", 64'(mc_bus.req.is_multicyc), 64'd1);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("divu_stall", 64'(stall), 64'd1);
            next_cycle();
        end
        applyStimulus(1'b0, OP_NOP, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("flush_drops_stall", 64'(stall), 64'd0);
        next_cycle();
        applyStimulus(1'b1, OP_MULT, 32'd2, 32'd3, 1'b0);
        for (int k = 6; k <= 37; k++) begin
            @(negedge clk);
            checkOutput("drain_flags", 64'({mc_bus.req.is_multicyc, stall, mc_bus.resp.valid}),
                        (k < 37) ? 64'b010 : 64'b011);
            next_cycle();
        end
        run_op("mult_after_drain", OP_MULT, 32'd2, 32'd3, 2, 64'h12345678_CAFEBABE, 64'd6);

        run_op("multu1", OP_MULTU, 32'd2, 32'd3, 2, 64'd6, 64'd6);
        run_op("multu2", OP_MULTU, 32'd4, 32'd5, 2, 64'd6, 64'd20);
        applyStimulus(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("multu_final_hilo", hilo, 64'd20);
        next_cycle();

        applyStimulus(1'b1, OP_DIV, 32'd20, 32'd3, 1'b0);
        @(negedge clk);
        checkOutput("div_rst_issue", 64'(mc_bus.req.is_multicyc), 64'd1);
        repeat (10) next_cycle();
        rst = 1'b1;
        applyStimulus(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mid_rst_outputs", 64'({mc_bus.req.is_multicyc, stall}), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_hilo", hilo, 64'd0);
        checkOutput("post_rst_stall", 64'(stall), 64'd0);
        checkOutput("post_rst_ready", 64'(mc_bus.resp.ready), 64'd1);
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            @(negedge clk);
            checkOutput("post_rst_no_commit", {hilo[62:0], mc_bus.resp.valid}, 64'd0);
        end

        next_cycle();
        @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
